menu_controller: RTL and testbench

//  Game/menu sequencer between the keyboard decoder and the menu overlay/game logic.

---
 rtl/menu_controller.sv | 98 +++++++++
 tb/tb_menu_controller.sv | 139 +++++++++++++
 2 files changed

// File: rtl/menu_controller.sv
// menu_controller: game/menu sequencer with key holdoff and frame-aligned overlay enable.
// Optional MENU_CTRL_KEYCNT_EN adds key_cnt, the count of accepted keys.
module menu_controller #(
  parameter int MENU_ITEMS   = 3,
  parameter int SPEED_LEVELS = 4,
  parameter int KEY_HOLDOFF  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key,
  input  logic       key_valid,
  input  logic       vsync_in,
  input  logic       game_over_in,
  output logic       game_run,
  output logic       game_start,
  output logic       menu_open,
  output logic       menu_visible,
`ifdef MENU_CTRL_KEYCNT_EN
  output logic [15:0] key_cnt,
`endif
  output logic [1:0] cursor,
  output logic [1:0] speed_level
);
  localparam int HW = $clog2(KEY_HOLDOFF + 1);
  localparam logic [7:0] K_ENTER = 8'h0d, K_ESC = 8'h1b, K_UP = 8'h77, K_DOWN = 8'h73;
  localparam logic [7:0] MI8 = 8'(MENU_ITEMS);
  localparam logic [1:0] CMAX = 2'(MENU_ITEMS - 1), SMAX = 2'(SPEED_LEVELS - 1);
  typedef enum logic [1:0] {IDLE, RUN, MENU, OVER} state_t;
  state_t state, state_nx;
  logic [HW-1:0] hold;
  logic [1:0] cursor_nx, speed_nx;
  logic [7:0] digit;
  logic start_nx, acc, kv, v_d;
  assign game_run  = state == RUN;
  assign menu_open = state == MENU;
  assign kv        = key_valid && hold == '0;
  assign digit     = key - 8'h31;
  always_comb begin
    state_nx  = state;
    cursor_nx = cursor;
    speed_nx  = speed_level;
    start_nx  = 1'b0;
    acc       = 1'b0;
    case (state)
      IDLE, OVER: if (kv && key == K_ENTER) begin
        acc = 1'b1;
        state_nx = RUN;
        start_nx = 1'b1;
      end
      RUN: if (game_over_in) state_nx = OVER;
        else if (kv && key == K_ESC) begin
          acc = 1'b1;
          state_nx = MENU;
          cursor_nx = 2'd0;
        end
      MENU: if (kv) begin
        acc = 1'b1;
        if (key == K_ESC) state_nx = RUN;
        else if (key == K_UP) cursor_nx = cursor == 2'd0 ? CMAX : cursor - 2'd1;
        else if (key == K_DOWN) cursor_nx = cursor == CMAX ? 2'd0 : cursor + 2'd1;
        else if (key >= 8'h31 && key <= 8'h33 && digit < MI8) cursor_nx = digit[1:0];
        else if (key == K_ENTER && cursor == 2'd0) state_nx = RUN;
        else if (key == K_ENTER && cursor == 2'd1) speed_nx = speed_level == SMAX ? 2'd0 : speed_level + 2'd1;
        else if (key == K_ENTER && cursor == 2'd2) begin
          state_nx = RUN;
          start_nx = 1'b1;
        end
        else acc = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cursor       <= 2'd0;
      speed_level  <= 2'd0;
      game_start   <= 1'b0;
      hold         <= '0;
      v_d          <= 1'b0;
      menu_visible <= 1'b0;
    end else begin
      state       <= state_nx;
      cursor      <= cursor_nx;
      speed_level <= speed_nx;
      game_start  <= start_nx;
      hold        <= acc ? HW'(KEY_HOLDOFF) : (hold != '0 ? hold - HW'(1) : hold);
      v_d         <= vsync_in;
      if (vsync_in && !v_d) menu_visible <= menu_open;
    end
  end
`ifdef MENU_CTRL_KEYCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_cnt <= 16'd0;
    else if (acc) key_cnt <= key_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_menu_controller.sv
// tb_menu_controller: directed vector table, hand sequences and random stimulus against a reference model.
module tb_menu_controller;
  localparam int MI = 3, SL = 4, HO = 4;
  logic clk = 0, rst_n = 0;
  logic [7:0] key = 0;
  logic key_valid = 0, vsync_in = 0, game_over_in = 0;
  logic game_run, game_start, menu_open, menu_visible;
  logic [1:0] cursor, speed_level;
`ifdef MENU_CTRL_KEYCNT_EN
  logic [15:0] key_cnt;
`endif
  menu_controller #(.MENU_ITEMS(MI), .SPEED_LEVELS(SL), .KEY_HOLDOFF(HO)) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .key_valid(key_valid), .vsync_in(vsync_in),
    .game_over_in(game_over_in), .game_run(game_run), .game_start(game_start),
    .menu_open(menu_open), .menu_visible(menu_visible),
`ifdef MENU_CTRL_KEYCNT_EN
    .key_cnt(key_cnt),
`endif
    .cursor(cursor), .speed_level(speed_level));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic vsl = 0;
  // model: mode 0 idle, 1 run, 2 menu, 3 over; m_since = cycles since last accepted key
  int m_mode, m_cur, m_spd, m_vis, m_prevvs, m_since, m_start, m_cnt;
  task automatic m_reset();
    m_mode = 0; m_cur = 0; m_spd = 0; m_vis = 0; m_prevvs = 0; m_since = HO + 1; m_start = 0; m_cnt = 0;
  endtask
  task automatic model(input logic [7:0] k, input logic kv, input logic go, input logic vs);
    bit ok, acc;
    int nm;
    ok = kv && m_since > HO;
    acc = 0;
    nm = m_mode;
    m_start = 0;
    if (!m_prevvs && vs) m_vis = (m_mode == 2);
    m_prevvs = vs;
    case (m_mode)
      0, 3: if (ok && k == 8'h0d) begin acc = 1; nm = 1; m_start = 1; end
      1: if (go) nm = 3;
        else if (ok && k == 8'h1b) begin acc = 1; nm = 2; m_cur = 0; end
      2: if (ok) begin
        acc = 1;
        if (k == 8'h1b) nm = 1;
        else if (k == 8'h77) m_cur = (m_cur + MI - 1) % MI;
        else if (k == 8'h73) m_cur = (m_cur + 1) % MI;
        else if (k >= 8'h31 && k <= 8'h33 && int'(k) - 49 < MI) m_cur = int'(k) - 49;
        else if (k == 8'h0d && m_cur == 0) nm = 1;
        else if (k == 8'h0d && m_cur == 1) m_spd = (m_spd + 1) % SL;
        else if (k == 8'h0d && m_cur == 2) begin nm = 1; m_start = 1; end
        else acc = 0;
      end
      default: ;
    endcase
    m_since = acc ? 1 : m_since + 1;
    if (acc) m_cnt = (m_cnt + 1) % 65536;
    m_mode = nm;
  endtask
  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
    end
  endtask
  task automatic check_model(input string name);
    logic [7:0] e;
    e = {m_mode == 1, m_start[0], m_mode == 2, m_vis[0], 2'(m_cur), 2'(m_spd)};
    chk(name, {8'h0, game_run, game_start, menu_open, menu_visible, cursor, speed_level}, {8'h0, e});
`ifdef MENU_CTRL_KEYCNT_EN
    chk({name, "_cnt"}, key_cnt, 16'(m_cnt));
`endif
  endtask
  task automatic step(input logic [7:0] k, input logic kv, input logic go);
    @(negedge clk);
    key = k; key_valid = kv; game_over_in = go; vsync_in = vsl;
    @(posedge clk);
    model(k, kv, go, vsl);
    #1 check_model("model");
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(8'h00, 1'b0, 1'b0);
  endtask
  typedef struct {logic [7:0] k; logic kv; logic go; int gap; logic [6:0] exp;} vec_t;
  vec_t tbl[20];
  logic [7:0] ks[7];
  initial begin
    tbl = '{
      '{8'h00, 0, 0, 0, 7'b0_0_0_00_00}, '{8'h0d, 1, 0, 0, 7'b1_1_0_00_00},
      '{8'h00, 0, 0, 4, 7'b1_0_0_00_00}, '{8'h1b, 1, 0, 5, 7'b0_0_1_00_00},
      '{8'h77, 1, 0, 5, 7'b0_0_1_10_00}, '{8'h73, 1, 0, 5, 7'b0_0_1_00_00},
      '{8'h32, 1, 0, 5, 7'b0_0_1_01_00}, '{8'h0d, 1, 0, 5, 7'b0_0_1_01_01},
      '{8'h0d, 1, 0, 5, 7'b0_0_1_01_10}, '{8'h0d, 1, 0, 5, 7'b0_0_1_01_11},
      '{8'h0d, 1, 0, 1, 7'b0_0_1_01_00}, '{8'h0d, 1, 0, 5, 7'b0_0_1_01_00},
      '{8'h33, 1, 0, 5, 7'b0_0_1_10_00}, '{8'h0d, 1, 0, 5, 7'b1_1_0_10_00},
      '{8'h1b, 1, 1, 5, 7'b0_0_0_10_00}, '{8'h77, 1, 0, 0, 7'b0_0_0_10_00},
      '{8'h0d, 1, 0, 5, 7'b1_1_0_10_00}, '{8'h1b, 1, 0, 5, 7'b0_0_1_00_00},
      '{8'h1b, 1, 0, 5, 7'b1_0_0_00_00}, '{8'h00, 0, 1, 5, 7'b0_0_0_00_00}};
    ks = '{8'h0d, 8'h1b, 8'h77, 8'h73, 8'h31, 8'h32, 8'h33};
    m_reset();
    #1 chk("reset", {8'h0, game_run, game_start, menu_open, menu_visible, cursor, speed_level}, 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].k, tbl[i].kv, tbl[i].go);
      chk($sformatf("vec%0d", i), {9'h0, game_run, game_start, menu_open, cursor, speed_level}, {9'h0, tbl[i].exp});
      idle(tbl[i].gap);
    end
    step(8'h0d, 1, 0); idle(5);
    step(8'h1b, 1, 0); idle(5);
    chk("vis_before_vsync", {15'h0, menu_visible}, 16'h0);
    vsl = 1; step(8'h00, 0, 0);
    chk("vis_open", {15'h0, menu_visible}, 16'h1);
    idle(5);
    step(8'h1b, 1, 0);
    chk("closed_now", {15'h0, menu_open}, 16'h0);
    idle(3);
    chk("vis_hold", {15'h0, menu_visible}, 16'h1);
    vsl = 0; step(8'h00, 0, 0);
    chk("vis_fall", {15'h0, menu_visible}, 16'h1);
    vsl = 1; step(8'h00, 0, 0);
    chk("vis_close", {15'h0, menu_visible}, 16'h0);
    @(negedge clk);
    rst_n = 0;
    m_reset();
    vsl = 0; vsync_in = 0; key_valid = 0;
    #1 chk("mid_reset", {8'h0, game_run, game_start, menu_open, menu_visible, cursor, speed_level}, 16'h0);
    #2 rst_n = 1;
    for (int i = 0; i < 3000; i++) begin
      int idx;
      logic [7:0] k;
      if ($urandom_range(0, 15) == 0) vsl = ~vsl;
      idx = $urandom_range(0, 7);
      k = idx == 7 ? 8'($urandom) : ks[idx];
      step(k, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
